// File: rtl/ascii_uart_pkg.sv
// Shared definitions for the ASCII UART sender: state encoding, terminator
// characters and default sizing.
package ascii_uart_pkg;

  localparam int unsigned DEF_NUM_CHARS    = 10;
  localparam int unsigned DEF_CLKS_PER_BIT = 104;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/ascii_uart_sender_if.sv
// Load/status bundle between the hex-to-ASCII converter, the sequencer and
// the UART sender (tx is the CMOD S7 UART TX pin).
interface ascii_uart_sender_if #(
  parameter int unsigned NUM_CHARS = 10
);

  logic                     data_valid;
  logic [8*NUM_CHARS-1:0]   data;
  logic                     tx;
  logic                     busy;
  logic                     done;
  logic                     overrun;

  modport master (
    output data_valid, data,
    input  tx, busy, done, overrun
  );

  modport slave (
    input  data_valid, data,
    output tx, busy, done, overrun
  );

endinterface

// File: rtl/ascii_uart_sender_tx_byte.sv
// uart_tx_byte: one 8N1 frame per go strobe. A go presented in the final
// stop-bit cycle chains the next frame with no idle gap.
module uart_tx_byte
  import ascii_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       byte_done_c_o
);

  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  byte_q;
  logic        tx_q;

  logic        cnt_last_c;
  logic        accept_c;
  logic [2:0]  next_bit_c;

  assign cnt_last_c    = (clk_cnt_q == CNT_LAST);
  assign byte_done_c_o = (state_q == STOP) && cnt_last_c;
  assign accept_c      = go_i && ((state_q == IDLE) || byte_done_c_o);
  assign next_bit_c    = bit_idx_q + 3'd1;
  assign tx_o          = tx_q;

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      tx_q      <= 1'b1;
    end else if (accept_c) begin
      state_q   <= START;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= byte_i;
      tx_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (cnt_last_c) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= byte_q[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (cnt_last_c) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= next_bit_c;
              tx_q      <= byte_q[next_bit_c];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (cnt_last_c) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            tx_q      <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ascii_uart_sender.sv
// ascii_uart_sender: captures a NUM_CHARS ASCII buffer on data_valid and
// sends it byte 0 first as back-to-back 8N1 frames.
// Optional: define ASCII_UART_SENDER_CRLF_EN to append CR, LF frames.
module ascii_uart_sender
  import ascii_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned NUM_CHARS    = DEF_NUM_CHARS
) (
  input  logic                 clk,
  input  logic                 reset,
  ascii_uart_sender_if.slave   bus
);

`ifdef ASCII_UART_SENDER_CRLF_EN
  localparam int unsigned TOTAL = NUM_CHARS + 2;
`else
  localparam int unsigned TOTAL = NUM_CHARS;
`endif
  localparam int unsigned      IDX_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;
  logic                   overrun_q,  overrun_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [8*NUM_CHARS-1:0] shadow_q,   shadow_d;

  logic                   start_c;
  logic                   more_c;
  logic                   go_c;
  logic                   byte_done_c;
  logic [IDX_W-1:0]       nxt_idx_c;
  logic [7:0]             next_byte_c;

  assign start_c = !busy_q && bus.data_valid;
  assign more_c  = (byte_idx_q != LAST_IDX);
  assign go_c    = start_c || (busy_q && byte_done_c && more_c);

  // Byte offered to the frame engine: fresh buffer byte 0 on a load,
  // otherwise the next shadow byte or terminator.
  always_comb begin
    nxt_idx_c   = byte_idx_q + IDX_W'(1);
    next_byte_c = 8'h00;
    if (start_c) begin
      next_byte_c = bus.data[7:0];
    end else begin
      for (int k = 0; k < int'(NUM_CHARS); k++) begin
        if (nxt_idx_c == IDX_W'(k)) next_byte_c = shadow_q[8*k +: 8];
      end
`ifdef ASCII_UART_SENDER_CRLF_EN
      if (nxt_idx_c == IDX_W'(NUM_CHARS))     next_byte_c = ASCII_CR;
      if (nxt_idx_c == IDX_W'(NUM_CHARS + 1)) next_byte_c = ASCII_LF;
`endif
    end
  end

  // Buffer sequencing and status next-state.
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = busy_q && bus.data_valid;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    if (start_c) begin
      busy_d     = 1'b1;
      byte_idx_d = '0;
      shadow_d   = bus.data;
    end else if (busy_q && byte_done_c) begin
      if (more_c) begin
        byte_idx_d = nxt_idx_c;
      end else begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Status and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk           (clk),
    .reset         (reset),
    .go_i          (go_c),
    .byte_i        (next_byte_c),
    .tx_o          (bus.tx),
    .byte_done_c_o (byte_done_c)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_ascii_uart_sender.sv
// Bench for ascii_uart_sender: byte scoreboard fed by a UART line decoder,
// plus per-cycle busy/done/overrun/idle-line expectations.
module tb_ascii_uart_sender;

  localparam int CPB   = 4;
  localparam int NCH   = 10;
`ifdef ASCII_UART_SENDER_CRLF_EN
  localparam int TOTAL = NCH + 2;
`else
  localparam int TOTAL = NCH;
`endif
  localparam int F = TOTAL * 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ascii_uart_sender_if #(.NUM_CHARS(NCH)) bus ();

  ascii_uart_sender #(
    .CLKS_PER_BIT (CPB),
    .NUM_CHARS    (NCH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: one buffer window [bstart, bend), expected bytes and event cycles.
  int       bstart = 0;
  int       bend   = 0;
  logic [7:0] exp_bytes[$];
  int       done_q[$];
  int       ovr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [79:0] rand80();
    return 80'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Per-cycle status monitor.
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_ovr;
    int   d;
    if (!reset) begin
      exp_busy = (cyc >= bstart) && (cyc < bend);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      if (!exp_busy) chk("tx_idle", 32'(bus.tx), 32'd1);
      exp_ovr = 1'b0;
      if (ovr_q.size() > 0 && ovr_q[0] == cyc) begin
        exp_ovr = 1'b1;
        d = ovr_q.pop_front();
      end
      chk("overrun", 32'(bus.overrun), 32'(exp_ovr));
      if (bus.done) begin
        if (done_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d));
          chk("done_busy_low", 32'(bus.busy), 32'd0);
        end
      end else if (done_q.size() > 0 && cyc > done_q[0]) begin
        d = done_q.pop_front();
        chk("done_missing", 32'd0, 32'd1);
      end
    end
  end

  // UART line decoder feeding the byte scoreboard.
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (bus.tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
    end
    if (!reset && rx_active) begin
      if (rx_cnt == CPB / 2) chk("start_bit", 32'(bus.tx), 32'd0);
      for (int i = 1; i <= 8; i++)
        if (rx_cnt == CPB * i + CPB / 2) rx_byte[i-1] = bus.tx;
      if (rx_cnt == CPB * 9 + CPB / 2) begin
        chk("stop_bit", 32'(bus.tx), 32'd1);
        if (exp_bytes.size() == 0) begin
          chk("byte_unexpected", 32'(rx_byte), 32'h100);
        end else begin
          e = exp_bytes.pop_front();
          chk("byte", 32'(rx_byte), 32'(e));
        end
      end
      if (rx_cnt == CPB * 10 - 1) rx_active = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      bus.data = rand80();
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a one-cycle strobe; the model decides acceptance from its busy window.
  task automatic strobe(input logic [79:0] d);
    bit acc;
    acc = !((cyc >= bstart) && (cyc < bend));
    bus.data_valid = 1'b1;
    bus.data = d;
    if (acc) begin
      for (int k = 0; k < NCH; k++) exp_bytes.push_back(d[8*k +: 8]);
`ifdef ASCII_UART_SENDER_CRLF_EN
      exp_bytes.push_back(8'h0D);
      exp_bytes.push_back(8'h0A);
`endif
      bstart = cyc + 1;
      bend   = cyc + 1 + F;
      done_q.push_back(bend);
    end else begin
      ovr_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.data = rand80();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if (cyc + 1 < bend) bend = cyc + 1;
    done_q.delete();
    ovr_q.delete();
    exp_bytes.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc < bend && guard < 4 * F) begin
      tick(1);
      guard++;
    end
    if (guard >= 4 * F) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [79:0] d;
    bus.data_valid = 1'b0;
    bus.data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Quiet line after reset.
    tick(50);

    // Single 'A' in byte 0, rest random.
    d = rand80();
    d[7:0] = 8'h41;
    strobe(d);
    wait_idle();
    tick(3);

    // "0123456789", byte 0 = '0'.
    for (int k = 0; k < NCH; k++) d[8*k +: 8] = 8'(8'h30 + k);
    strobe(d);
    wait_idle();
    tick(2);

    // Overrun at cycle 100 with changing data, then strobe coincident with done.
    strobe(rand80());
    tick(98);
    strobe(rand80());
    wait_idle();
    strobe(rand80());
    wait_idle();
    tick(2);

    // Reset mid DATA bits of byte 1, then a fresh buffer.
    strobe(rand80());
    tick(56);
    do_reset();
    tick(5);
    strobe(rand80());
    wait_idle();

    // Random buffers, gaps and stray strobes.
    for (int n = 0; n < 3; n++) begin
      tick($urandom_range(0, 6));
      strobe(rand80());
      tick($urandom_range(1, F - 2));
      strobe(rand80());
      wait_idle();
    end
    tick(45);

    chk("bytes_left", 32'(exp_bytes.size()), 32'd0);
    chk("done_left", 32'(done_q.size()), 32'd0);
    chk("overrun_left", 32'(ovr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
